// File: rtl/lfsr_stream_checker.sv
// Self-synchronising checker for a Fibonacci LFSR word stream: predicts each word from the
// previous one, acquires/loses lock on runs of matches/misses and counts errors while locked.
module lfsr_stream_checker #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned TAP_HI   = 3,
    parameter int unsigned TAP_LO   = 1,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             stuck_o
);

    typedef enum logic [0:0] {StSearch, StLocked} state_e;

    localparam logic [3:0] LockLast = 4'(LOCK_CNT - 1);
    localparam logic [3:0] LossLast = 4'(LOSS_CNT - 1);

    state_e           state_q;
    logic [WIDTH-1:0] prev_q;
    logic             have_prev_q;
    logic [3:0]       match_cnt_q;
    logic [3:0]       miss_cnt_q;

    logic [WIDTH-1:0] pred;
    logic             match;
    logic [CNT_W-1:0] err_cnt_next;

    assign pred  = {prev_q[WIDTH-2:0], prev_q[TAP_HI] ^ prev_q[TAP_LO]};
    assign match = have_prev_q && (data_i == pred) && (data_i != '0);

    // A clear coincident with an error restarts the count at one so that error is kept.
    always_comb begin
        err_cnt_next = err_cnt_o;
        if (clear_i) begin
            err_cnt_next = CNT_W'(1);
        end else if (!(&err_cnt_o)) begin
            err_cnt_next = err_cnt_o + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StSearch;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_o    <= 1'b0;
            err_o       <= 1'b0;
            err_cnt_o   <= '0;
            stuck_o     <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (clear_i) begin
                err_cnt_o <= '0;
            end
            if (valid_i) begin
                prev_q      <= data_i;
                have_prev_q <= 1'b1;
                stuck_o     <= (data_i == '0);
                unique case (state_q)
                    StSearch: begin
                        if (match) begin
                            if (match_cnt_q == LockLast) begin
                                state_q     <= StLocked;
                                locked_o    <= 1'b1;
                                match_cnt_q <= '0;
                                miss_cnt_q  <= '0;
                            end else begin
                                match_cnt_q <= match_cnt_q + 4'd1;
                            end
                        end else begin
                            match_cnt_q <= '0;
                        end
                    end
                    StLocked: begin
                        if (match) begin
                            miss_cnt_q <= '0;
                        end else begin
                            err_o     <= 1'b1;
                            err_cnt_o <= err_cnt_next;
                            if (miss_cnt_q == LossLast) begin
                                state_q     <= StSearch;
                                locked_o    <= 1'b0;
                                miss_cnt_q  <= '0;
                                match_cnt_q <= '0;
                            end else begin
                                miss_cnt_q <= miss_cnt_q + 4'd1;
                            end
                        end
                    end
                    default: state_q <= StSearch;
                endcase
            end
        end
    end

endmodule
